// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing (640x480@60 defaults).
// Renderers and sprite units import this so visible bounds agree.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic SYNC_ACTIVE = 1'b0;

  // True when lo <= v < lo+len
  function automatic logic in_win(
    input logic [9:0] v,
    input int         lo,
    input int         len
  );
    return (v >= 10'(lo)) && (v < 10'(lo + len));
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel divider, X/Y counters, and a registered
// sync/blank/strobe bank decoded from the next coordinates.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_clk,
  output logic       pix_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [1:0] DIV_MAX  = 2'(CLK_DIV - 1);
  localparam logic [1:0] DIV_HALF = 2'(CLK_DIV / 2);

  logic [1:0] r_div;
  logic       r_pclk;
  logic       r_pen;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_fs;
  logic       r_vbs;

  logic [1:0] w_div_nxt;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;

  assign w_div_nxt = (r_div == DIV_MAX) ? 2'd0 : r_div + 2'd1;

  always_comb begin
    w_x_nxt = r_x + 10'd1;
    w_y_nxt = r_y;
    if (r_x == 10'(H_TOT - 1)) begin
      w_x_nxt = '0;
      if (r_y == 10'(V_TOT - 1)) w_y_nxt = '0;
      else w_y_nxt = r_y + 10'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_div   <= '0;
      r_pclk  <= 1'b0;
      r_pen   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_hs    <= ~SYNC_ACTIVE;
      r_vs    <= ~SYNC_ACTIVE;
      r_blank <= 1'b0;
      r_fs    <= 1'b0;
      r_vbs   <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_pclk <= (w_div_nxt >= DIV_HALF);
      r_pen  <= (r_div == DIV_MAX);
      // Decode from next coordinates so outputs move with DrawX/DrawY
      if (r_pen) begin
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_hs    <= in_win(w_x_nxt, H_VISIBLE + H_FRONT, H_SYNC) ?
                   SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_vs    <= in_win(w_y_nxt, V_VISIBLE + V_FRONT, V_SYNC) ?
                   SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_blank <= (w_x_nxt < 10'(H_VISIBLE)) &&
                   (w_y_nxt < 10'(V_VISIBLE));
        r_fs    <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
        r_vbs   <= (w_x_nxt == 10'd0) &&
                   (w_y_nxt == 10'(V_VISIBLE));
      end
    end
  end

  assign pixel_clk    = r_pclk;
  assign pix_en       = r_pen;
  assign hs           = r_hs;
  assign vs           = r_vs;
  assign blank        = r_blank;
  assign sync         = 1'b0;
  assign DrawX        = r_x;
  assign DrawY        = r_y;
  assign frame_start  = r_fs;
  assign vblank_start = r_vbs;

endmodule
